// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its consumers.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_SCAN,
    ST_PUSH,
    ST_HELD
  } state_t;

  function automatic int unsigned code_width(input int unsigned rows, input int unsigned cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  // Raw code to ASCII legend: 0-9 then A-F.
  function automatic logic [7:0] code_legend(input logic [3:0] code);
    if (code < 4'd10) return 8'h30 + {4'h0, code};
    else return 8'h41 + {4'h0, code} - 8'd10;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO with registered full/empty and a valid/ready read side.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q, count_d;
  logic             empty_q, full_q;
  logic             do_rd, do_wr;

  // A read in the same cycle frees the slot, so a write on full still lands.
  assign do_rd = rd_en & ~empty_q;
  assign do_wr = wr_en & (~full_q | do_rd);

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH_V);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign valid   = ~empty_q;
  assign full    = full_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: debounced press detection, column scan, key FIFO.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned DEBOUNCE_CYC = 2000000,
  parameter int unsigned SETTLE_CYC   = 2,
  parameter int unsigned FIFO_DEPTH   = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ROWS-1:0]                     row_data,
  output logic [COLS-1:0]                     col_data,
  output logic [code_width(ROWS, COLS)-1:0]   key_code,
  output logic                                key_valid,
  input  logic                                key_ready,
  output logic                                overflow
);

  localparam int unsigned CODE_W = code_width(ROWS, COLS);
  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYC);
  localparam int unsigned SET_W  = cnt_width(SETTLE_CYC);
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);

  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYC);
  localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE_CYC);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d, db_inc;
  logic [SET_W-1:0]  set_q, set_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [ROW_W-1:0]  hit_row;
  logic              hit;
  logic              wr;
  logic              full;
  logic              overflow_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             armed_q, armed_d;

  assign rpt_inc = (rpt_q == '1) ? rpt_q : rpt_q + 1'b1;
`endif

  assign db_inc = (db_q == DB_MAX) ? db_q : db_q + 1'b1;

  // Lowest-index low row wins.
  always_comb begin
    hit     = 1'b0;
    hit_row = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (!row_data[i] && !hit) begin
        hit     = 1'b1;
        hit_row = ROW_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    set_d   = set_q;
    col_d   = col_q;
    code_d  = code_q;
    wr      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = '0;
    armed_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        db_d = '0;
        if (hit) state_d = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!hit) begin
          state_d = ST_IDLE;
          db_d    = '0;
        end else if (db_inc == DB_MAX) begin
          state_d = ST_SCAN;
          db_d    = '0;
          col_d   = '0;
          set_d   = '0;
        end else begin
          db_d = db_inc;
        end
      end
      ST_SCAN: begin
        if (set_q == SET_MAX) begin
          if (hit) begin
            state_d = ST_PUSH;
            code_d  = CODE_W'(32'(hit_row) * COLS + 32'(col_q));
          end else if (col_q == COL_LAST) begin
            state_d = ST_IDLE;
          end else begin
            col_d = col_q + 1'b1;
            set_d = '0;
          end
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      ST_PUSH: begin
        wr      = 1'b1;
        state_d = ST_HELD;
        db_d    = '0;
      end
      ST_HELD: begin
        if (hit) begin
          db_d = '0;
`ifdef KEYPAD_REPEAT_EN
          // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
          armed_d = armed_q;
          if (rpt_inc == (armed_q ? RPT_PERIOD_V : RPT_DELAY_V)) begin
            wr      = 1'b1;
            rpt_d   = '0;
            armed_d = 1'b1;
          end else begin
            rpt_d = rpt_inc;
          end
`endif
        end else if (db_inc == DB_MAX) begin
          state_d = ST_IDLE;
          db_d    = '0;
        end else begin
          db_d = db_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      db_q       <= '0;
      set_q      <= '0;
      col_q      <= '0;
      code_q     <= '0;
      overflow_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q      <= '0;
      armed_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      db_q       <= db_d;
      set_q      <= set_d;
      col_q      <= col_d;
      code_q     <= code_d;
      overflow_q <= overflow_q | (wr & full & ~(key_valid & key_ready));
`ifdef KEYPAD_REPEAT_EN
      rpt_q      <= rpt_d;
      armed_q    <= armed_d;
`endif
    end
  end

  always_comb begin
    col_data = '0;
    if (state_q == ST_SCAN) col_data = ~(COLS'(1) << col_q);
  end

  assign overflow = overflow_q;

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (code_q),
    .full    (full),
    .rd_en   (key_ready),
    .rd_data (key_code),
    .valid   (key_valid)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_data;
  logic [3:0]  col_data;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        overflow;
  logic [15:0] key_mask;
  logic [3:0]  force_low;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS         (4),
    .COLS         (4),
    .DEBOUNCE_CYC (8),
    .SETTLE_CYC   (2),
    .FIFO_DEPTH   (4)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY  (100),
    .REPEAT_PERIOD (20)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_data  (row_data),
    .col_data  (col_data),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  // Closed switch at (r,c) pulls row r low while column c is strobed low.
  always_comb begin
    row_data = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !col_data[c]) row_data[r] = 1'b0;
    row_data = row_data & ~force_low;
  end

  typedef struct {
    logic [15:0] mask;
    int          code;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_check(input logic [15:0] mask, input int code, input int lat, input string tag);
    int n;
    int seen;
    int first_code;
    int pulses;
    n          = 0;
    seen       = 0;
    first_code = -1;
    key_mask   = mask;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (key_valid) begin
        seen       = 1;
        first_code = int'(key_code);
      end
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_code"}, first_code, code);
    pulses = seen;
    repeat (45) begin
      tick();
      if (key_valid) pulses++;
    end
    check({tag, "_pushes_held"}, pulses, 1);
    key_mask = '0;
    pulses   = 0;
    repeat (30) begin
      tick();
      if (key_valid) pulses++;
    end
    check({tag, "_pushes_release"}, pulses, 0);
    check({tag, "_col_idle"}, int'(col_data), 0);
  endtask

  task automatic press_release(input int code);
    key_mask = 16'(1) << code;
    repeat (40) tick();
    key_mask = '0;
    repeat (30) tick();
  endtask

  initial begin
    int n;
    int found;
    int cnt;
    int nrec;
    int offs[8];
    int exp_offs[4];
    int exp_n;

    vecs[0] = '{16'h0040, 6, 19};
    vecs[1] = '{16'h0001, 0, 13};
    vecs[2] = '{16'h8000, 15, 22};
    vecs[3] = '{16'h1000, 12, 13};
    vecs[4] = '{16'h2002, 1, 16};
    vecs[5] = '{16'h0024, 5, 16};
    vecs[6] = '{16'h0480, 10, 19};

    rst       = 1'b1;
    key_mask  = '0;
    force_low = '0;
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_col_data", int'(col_data), 0);
    check("reset_key_code", int'(key_code), 0);
    check("reset_key_valid", int'(key_valid), 0);
    check("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Short contact shorter than the debounce window.
    force_low = 4'b0001;
    cnt = 0;
    n   = 0;
    repeat (5) begin
      tick();
      if (key_valid) cnt++;
      if (col_data != 4'b0000) n++;
    end
    force_low = '0;
    repeat (30) begin
      tick();
      if (key_valid) cnt++;
      if (col_data != 4'b0000) n++;
    end
    check("bounce_no_push", cnt, 0);
    check("bounce_no_scan", n, 0);
    check("bounce_col_idle", int'(col_data), 0);

    for (int i = 0; i < 7; i++)
      press_check(vecs[i].mask, vecs[i].code, vecs[i].lat, $sformatf("vec%0d", i));

    // Stalled consumer: fifth key is dropped.
    key_ready = 1'b0;
    for (int k = 1; k <= 4; k++) press_release(k);
    check("ovf_full_valid", int'(key_valid), 1);
    check("ovf_not_yet", int'(overflow), 0);
    press_release(5);
    check("ovf_set", int'(overflow), 1);
    check("ovf_head_stable", int'(key_code), 1);
    key_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain%0d_valid", k), int'(key_valid), 1);
      check($sformatf("drain%0d_code", k), int'(key_code), k);
      tick();
    end
    check("drain_empty", int'(key_valid), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Reset in the middle of scanning column 2, with an entry queued.
    key_ready = 1'b0;
    press_release(3);
    check("rst_pre_valid", int'(key_valid), 1);
    key_mask = 16'h0040;
    found = 0;
    n     = 0;
    while (!found && n < 100) begin
      tick();
      n++;
      if (col_data == 4'b1011) found = 1;
    end
    check("rst_reached_col2", found, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_col_data", int'(col_data), 0);
    check("rst_mid_key_valid", int'(key_valid), 0);
    check("rst_mid_overflow", int'(overflow), 0);
    @(negedge clk);
    key_mask = '0;
    repeat (2) tick();
    rst       = 1'b0;
    key_ready = 1'b1;
    repeat (3) tick();
    press_check(16'h0040, 6, 19, "post_rst");

    // Key 9 held for 145 cycles after its first push.
`ifdef KEYPAD_REPEAT_EN
    exp_n    = 4;
    exp_offs = '{0, 100, 120, 140};
`else
    exp_n    = 1;
    exp_offs = '{0, 0, 0, 0};
`endif
    key_mask = 16'h0200;
    found = 0;
    n     = 0;
    while (!found && n < 200) begin
      tick();
      n++;
      if (key_valid) found = 1;
    end
    check("rpt_first_latency", n, 16);
    check("rpt_first_code", int'(key_code), 9);
    nrec    = 1;
    offs[0] = 0;
    for (int k = 1; k <= 145; k++) begin
      tick();
      if (key_valid) begin
        if (nrec < 8) offs[nrec] = k;
        nrec++;
        check($sformatf("rpt_code_at_%0d", k), int'(key_code), 9);
      end
    end
    key_mask = '0;
    repeat (30) begin
      tick();
      if (key_valid) nrec++;
    end
    check("rpt_count", nrec, exp_n);
    for (int k = 1; k < 4; k++)
      if (k < exp_n && k < nrec) check($sformatf("rpt_offset%0d", k), offs[k], exp_offs[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
